sa_result_drain: RTL and testbench
==================================

# sa_result_drain

Streaming read-back engine for the systolic matmul output memory. On a start pulse (driven by the matmul `o_done`), it reads result rows from the output SRAM in ascending address order and presents them on a valid/ready stream. A 2-entry skid FIFO hides the SRAM's 1-cycle read latency. The block replaces the bench's backdoor memory dump with a real drain path toward the host interface.

## Interface
Parameters:
- `ADD_DATAWIDTH`, 8, width of one psum element
- `NUM_COLS`, 4, psum elements per output row
- `DEPTH`, 4, rows in the output memory (M)
- `WORD_W`, `NUM_COLS*ADD_DATAWIDTH`, derived row width
- `ADDR_W`, `$clog2(DEPTH)` (min 1), derived address width

Ports:
- `clk` in 1: single clock; all logic is on its rising edge
- `rst_n` in 1: reset, asynchronous and active-low
- `i_start` in 1: 1-cycle start pulse; ignored unless IDLE
- `i_len` in `ADDR_W+1`: number of rows to drain, sampled with `i_start`
- `o_mem_rd_en` in/out: out 1, SRAM read enable
- `o_mem_addr` out `ADDR_W`: SRAM read address
- `i_mem_rdata` in `WORD_W`: SRAM data, valid the cycle after `o_mem_rd_en`
- `o_valid` out 1: stream word valid
- `o_data` out `WORD_W`: stream word (row N, col 0 in LSBs)
- `i_ready` in 1: downstream accept
- `o_busy` out 1: high in RUN
- `o_done` out 1: 1-cycle completion pulse

## Operation
- FSM states: IDLE, RUN.
- **IDLE → RUN:** on `i_start`. Latch `len = min(i_len, DEPTH)` and clear `rd_cnt`, `tx_cnt`, `inflight`, and the FIFO.
- **Zero length:** if the latched `len` is 0, stay in IDLE and pulse `o_done` on the next cycle. No reads are issued and `o_valid` stays low.
- **Read issue:** `o_mem_rd_en = RUN && rd_cnt < len && (fifo_cnt + inflight - pop) < 2`, where `pop = o_valid && i_ready`.
  - `o_mem_addr = rd_cnt`.
  - `rd_cnt` increments on each issue.
  - `inflight` is a 1-bit register equal to the previous cycle's `o_mem_rd_en`.
- **FIFO push:** when `inflight` is 1, push `i_mem_rdata`. The FIFO is 2 entries. Push and pop in the same cycle are both allowed, including when the FIFO is full, since the credit rule guarantees no overflow.
- **FIFO output:** `o_valid = fifo_cnt != 0`; `o_data` is the FIFO head.
- **Handshake:** `tx_cnt` increments on each handshake.
- **Completion:** on the handshake that makes `tx_cnt == len`, go RUN → IDLE and pulse `o_done` on the next cycle.
- **`i_start` while RUN:** ignored, with no effect on counters or `len`.
- **Reset (any time, including mid-drain):** return to IDLE, empty the FIFO, clear `inflight` and all counters. Any in-flight SRAM data is discarded.

## Timing
- Reset values: `o_valid=0`, `o_data=0`, `o_mem_rd_en=0`, `o_mem_addr=0`, `o_busy=0`, `o_done=0`.
- Start latency, with the start edge labelled E0:
  - `o_mem_rd_en` is high with addr 0 in the cycle after E0.
  - SRAM data is captured into the FIFO at E2.
  - `o_valid` first rises in the cycle after E2.
- Throughput: with `i_ready` held high, one word per cycle. A `len=L` drain completes its last handshake L−1 cycles after the first.
- Stream rule: once `o_valid` is high, `o_valid` and `o_data` must hold stable until the handshake.
- Backpressure: with `i_ready` low, at most 2 reads are outstanding (FIFO plus in-flight). Issue resumes the cycle after a pop frees a slot.
- `o_busy` is high from the cycle after E0 through the cycle of the final handshake.
- `o_done` is high exactly one cycle, the cycle after the final handshake, and is concurrent with `o_busy=0`.
- Back-to-back operation: a new `i_start` is accepted in the same cycle `o_done` is high.

## Test plan
- **Full throughput:** SRAM rows = 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D; `i_len=4`; `i_ready=1` → `o_valid` rises 2 edges after start, the 4 words are emitted in order on 4 consecutive cycles, then `o_done` pulses once.
- **Zero length:** `i_len=0` → no `o_mem_rd_en`, `o_valid` stays 0, `o_done` pulses the cycle after start.
- **Stall:** `i_len=4`, `i_ready=0` for 10 cycles after start → exactly 2 `o_mem_rd_en` pulses, `o_data=0x04030201` held stable; then `i_ready=1` → the remaining words follow in order with no loss or duplication.
- **Alternating ready:** `i_len=4`, `i_ready` toggling 1/0 → 4 handshakes, correct order, `o_done` after the 4th handshake.
- **Start while busy and clamping:** second `i_start` with `i_len=1` mid-drain → ignored, still 4 words. Separately, `i_len=7` with `DEPTH=4` → exactly 4 words, addresses 0–3.
- **Reset mid-drain:** assert `rst_n=0` after 2 handshakes → outputs return to reset values immediately. After release, a new start with `i_len=2` → words 0x04030201 and 0x08070605, with no stale data.

Source files
------------

// File: rtl/sa_result_drain.sv
// sa_result_drain
// Streams result rows out of the systolic matmul output SRAM. A start pulse
// kicks off an ascending-address read of up to DEPTH rows. The rows are
// presented on a valid/ready stream. A 2-entry skid FIFO, together with a
// one-bit in-flight tracker, hides the SRAM's single-cycle read latency.
//
// Ports
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_start       : 1-cycle start pulse, honoured only while idle
//   i_len         : rows to drain, sampled with i_start, clamped to DEPTH
//   o_mem_rd_en   : SRAM read enable
//   o_mem_addr    : SRAM read address
//   i_mem_rdata   : SRAM read data, valid the cycle after o_mem_rd_en
//   o_valid       : stream word valid
//   o_data        : stream word (column 0 in the LSBs)
//   i_ready       : downstream accept
//   o_busy        : high while a drain is running
//   o_done        : 1-cycle pulse after the final handshake or a zero-length start
module sa_result_drain #(
    parameter int ADD_DATAWIDTH = 8,
    parameter int NUM_COLS      = 4,
    parameter int DEPTH         = 4,
    parameter int WORD_W        = NUM_COLS * ADD_DATAWIDTH,
    parameter int ADDR_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic [ADDR_W:0]     i_len,
    output logic                o_mem_rd_en,
    output logic [ADDR_W-1:0]   o_mem_addr,
    input  logic [WORD_W-1:0]   i_mem_rdata,
    output logic                o_valid,
    output logic [WORD_W-1:0]   o_data,
    input  logic                i_ready,
    output logic                o_busy,
    output logic                o_done
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]   tx_cnt_q, tx_cnt_d;
    logic               inflight_q, inflight_d;
    logic               done_q, done_d;
    logic [WORD_W-1:0]  fifo_mem_q [2];
    logic [WORD_W-1:0]  fifo_mem_d [2];
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [1:0]         fifo_cnt_q, fifo_cnt_d;

    logic               pop;
    logic               push;
    logic               rd_en;
    logic [2:0]         occupancy;
    logic [CNT_W-1:0]   len_clamp;

    assign pop  = (fifo_cnt_q != 2'd0) && i_ready;
    assign push = inflight_q;

    // Slots that will still be occupied after this cycle's pop. A new read
    // may issue only if its data is guaranteed a slot when it returns.
    assign occupancy = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign rd_en     = (state_q == RUN) && (rd_cnt_q < len_q) && (occupancy < 3'd2);
    assign len_clamp = (i_len > DEPTH_C) ? DEPTH_C : i_len;

    assign o_mem_rd_en = rd_en;
    assign o_mem_addr  = rd_cnt_q[ADDR_W-1:0];
    assign o_valid     = (fifo_cnt_q != 2'd0);
    assign o_data      = fifo_mem_q[rd_ptr_q];
    assign o_busy      = (state_q == RUN);
    assign o_done      = done_q;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        rd_cnt_d   = rd_cnt_q;
        tx_cnt_d   = tx_cnt_q;
        inflight_d = rd_en;
        done_d     = 1'b0;
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;

        if (rd_en) begin
            rd_cnt_d = rd_cnt_q + ONE_C;
        end

        // Push and pop may coincide, even when the FIFO is full. In that
        // case the popped head is replaced and becomes the new tail.
        if (push) begin
            fifo_mem_d[wr_ptr_q] = i_mem_rdata;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    len_d      = len_clamp;
                    rd_cnt_d   = '0;
                    tx_cnt_d   = '0;
                    inflight_d = 1'b0;
                    wr_ptr_d   = 1'b0;
                    rd_ptr_d   = 1'b0;
                    fifo_cnt_d = 2'd0;
                    // A zero-length request completes immediately without
                    // touching the SRAM.
                    if (len_clamp == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (pop) begin
                    tx_cnt_d = tx_cnt_q + ONE_C;
                    if ((tx_cnt_q + ONE_C) == len_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            len_q         <= '0;
            rd_cnt_q      <= '0;
            tx_cnt_q      <= '0;
            inflight_q    <= 1'b0;
            done_q        <= 1'b0;
            fifo_mem_q[0] <= '0;
            fifo_mem_q[1] <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            fifo_cnt_q    <= 2'd0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            rd_cnt_q      <= rd_cnt_d;
            tx_cnt_q      <= tx_cnt_d;
            inflight_q    <= inflight_d;
            done_q        <= done_d;
            fifo_mem_q[0] <= fifo_mem_d[0];
            fifo_mem_q[1] <= fifo_mem_d[1];
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
        end
    end

endmodule

// File: tb/tb_sa_result_drain.sv
// tb_sa_result_drain
// Directed bench for sa_result_drain. It includes a behavioural SRAM with
// 1-cycle read latency and a scoreboard queue. The expected words are queued
// at start time and popped on every stream handshake.
module tb_sa_result_drain;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 2;

    logic                clk;
    logic                rst_n;
    logic                i_start;
    logic [ADDR_W:0]     i_len;
    logic                o_mem_rd_en;
    logic [ADDR_W-1:0]   o_mem_addr;
    logic [WORD_W-1:0]   i_mem_rdata;
    logic                o_valid;
    logic [WORD_W-1:0]   o_data;
    logic                i_ready;
    logic                o_busy;
    logic                o_done;

    logic [WORD_W-1:0]   sram [4];
    logic [WORD_W-1:0]   exp_q [$];
    logic [ADDR_W-1:0]   addr_log [$];
    int                  tests;
    int                  fails;
    int                  rd_pulses;
    int                  hs_cnt;
    logic                hold_pending;
    logic [WORD_W-1:0]   hold_data;

    sa_result_drain dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_len       (i_len),
        .o_mem_rd_en (o_mem_rd_en),
        .o_mem_addr  (o_mem_addr),
        .i_mem_rdata (i_mem_rdata),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .i_ready     (i_ready),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: data appears the cycle after the read enable. Otherwise
    // the bus carries garbage, so a mistimed capture shows up as a bad word.
    always @(posedge clk) begin
        if (o_mem_rd_en) i_mem_rdata <= sram[o_mem_addr];
        else             i_mem_rdata <= 32'hDEADBEEF;
    end

    task automatic check_output(input string tag, input logic [WORD_W-1:0] obs,
                                input logic [WORD_W-1:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Monitor: counts reads and handshakes, scoreboards every accepted word,
    // and enforces that a stalled word stays put.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check_output("hold_valid", {31'd0, o_valid}, 32'd1);
                check_output("hold_data", o_data, hold_data);
            end
            if (o_mem_rd_en) begin
                rd_pulses++;
                addr_log.push_back(o_mem_addr);
            end
            if (o_valid && i_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    check_output("word_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                end else begin
                    check_output("stream_word", o_data, exp_q.pop_front());
                end
            end
            hold_pending = o_valid && !i_ready;
            hold_data    = o_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        rd_pulses = 0;
        hs_cnt    = 0;
        addr_log.delete();
    endtask

    // Pulses start for one cycle and queues the words the drain should emit.
    // It returns one tick after the start edge.
    task automatic apply_stimulus(input logic [ADDR_W:0] len, input int n_words);
        for (int i = 0; i < n_words; i++) exp_q.push_back(sram[i]);
        i_start = 1'b1;
        i_len   = len;
        step();
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (o_done) break;
            step();
        end
        check_output("done_seen", {31'd0, o_done}, 32'd1);
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        hold_pending = 1'b0;
        sram[0] = 32'h04030201;
        sram[1] = 32'h08070605;
        sram[2] = 32'h0C0B0A09;
        sram[3] = 32'h100F0E0D;
        clear_stats();
        rst_n   = 1'b0;
        i_start = 1'b0;
        i_len   = '0;
        i_ready = 1'b0;

        // Reset values
        #3;
        check_output("rst_valid", {31'd0, o_valid}, 32'd0);
        check_output("rst_data", o_data, 32'd0);
        check_output("rst_rd_en", {31'd0, o_mem_rd_en}, 32'd0);
        check_output("rst_addr", {30'd0, o_mem_addr}, 32'd0);
        check_output("rst_busy", {31'd0, o_busy}, 32'd0);
        check_output("rst_done", {31'd0, o_done}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Full throughput
        $display("[TB] full throughput");
        i_ready = 1'b1;
        apply_stimulus(3'd4, 4);
        check_output("tp_rd_en0", {31'd0, o_mem_rd_en}, 32'd1);
        check_output("tp_addr0", {30'd0, o_mem_addr}, 32'd0);
        check_output("tp_busy", {31'd0, o_busy}, 32'd1);
        check_output("tp_valid_e1", {31'd0, o_valid}, 32'd0);
        step();
        check_output("tp_addr1", {30'd0, o_mem_addr}, 32'd1);
        check_output("tp_valid_e2", {31'd0, o_valid}, 32'd0);
        step();
        check_output("tp_valid_first", {31'd0, o_valid}, 32'd1);
        check_output("tp_data_first", o_data, 32'h04030201);
        for (int i = 1; i < 4; i++) begin
            step();
            check_output("tp_valid_run", {31'd0, o_valid}, 32'd1);
        end
        step();
        check_output("tp_done", {31'd0, o_done}, 32'd1);
        check_output("tp_busy_end", {31'd0, o_busy}, 32'd0);
        check_output("tp_valid_end", {31'd0, o_valid}, 32'd0);
        step();
        check_output("tp_done_once", {31'd0, o_done}, 32'd0);
        check_output("tp_q_empty", exp_q.size(), 32'd0);

        // Zero length
        $display("[TB] zero length");
        clear_stats();
        apply_stimulus(3'd0, 0);
        check_output("zl_done", {31'd0, o_done}, 32'd1);
        check_output("zl_busy", {31'd0, o_busy}, 32'd0);
        check_output("zl_valid", {31'd0, o_valid}, 32'd0);
        step();
        check_output("zl_done_once", {31'd0, o_done}, 32'd0);
        check_output("zl_reads", rd_pulses, 32'd0);

        // Stall with downstream not ready
        $display("[TB] stall");
        clear_stats();
        i_ready = 1'b0;
        apply_stimulus(3'd4, 4);
        for (int i = 0; i < 9; i++) step();
        check_output("st_reads", rd_pulses, 32'd2);
        check_output("st_valid", {31'd0, o_valid}, 32'd1);
        check_output("st_data", o_data, 32'h04030201);
        i_ready = 1'b1;
        wait_done(20);
        check_output("st_hs", hs_cnt, 32'd4);
        check_output("st_reads_total", rd_pulses, 32'd4);
        check_output("st_q_empty", exp_q.size(), 32'd0);
        step();

        // Alternating ready
        $display("[TB] alternating ready");
        clear_stats();
        i_ready = 1'b1;
        apply_stimulus(3'd4, 4);
        for (int i = 0; i < 40; i++) begin
            if (o_done) break;
            i_ready = ~i_ready;
            step();
        end
        check_output("alt_done", {31'd0, o_done}, 32'd1);
        check_output("alt_hs", hs_cnt, 32'd4);
        check_output("alt_q_empty", exp_q.size(), 32'd0);
        i_ready = 1'b1;
        step();

        // Start while busy is ignored
        $display("[TB] start while busy");
        clear_stats();
        apply_stimulus(3'd4, 4);
        step();
        i_start = 1'b1;
        i_len   = 3'd1;
        step();
        i_start = 1'b0;
        wait_done(20);
        check_output("sb_hs", hs_cnt, 32'd4);
        check_output("sb_q_empty", exp_q.size(), 32'd0);
        step();

        // Length clamped to DEPTH
        $display("[TB] length clamp");
        clear_stats();
        apply_stimulus(3'd7, 4);
        wait_done(20);
        check_output("cl_hs", hs_cnt, 32'd4);
        check_output("cl_reads", rd_pulses, 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (addr_log.size() > 0) check_output("cl_addr", {30'd0, addr_log.pop_front()}, i);
        end
        check_output("cl_q_empty", exp_q.size(), 32'd0);
        step();

        // Reset mid-drain, then recovery and back-to-back start
        $display("[TB] reset mid-drain");
        clear_stats();
        apply_stimulus(3'd4, 4);
        for (int i = 0; i < 20; i++) begin
            if (hs_cnt >= 2) break;
            step();
        end
        check_output("rm_two_hs", hs_cnt, 32'd2);
        rst_n = 1'b0;
        #1;
        check_output("rm_valid", {31'd0, o_valid}, 32'd0);
        check_output("rm_data", o_data, 32'd0);
        check_output("rm_rd_en", {31'd0, o_mem_rd_en}, 32'd0);
        check_output("rm_busy", {31'd0, o_busy}, 32'd0);
        check_output("rm_done", {31'd0, o_done}, 32'd0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        step();
        clear_stats();
        apply_stimulus(3'd2, 2);
        wait_done(20);
        check_output("rm_hs", hs_cnt, 32'd2);
        check_output("rm_q_empty", exp_q.size(), 32'd0);
        clear_stats();
        apply_stimulus(3'd1, 1);
        check_output("b2b_busy", {31'd0, o_busy}, 32'd1);
        wait_done(20);
        check_output("b2b_hs", hs_cnt, 32'd1);
        check_output("b2b_q_empty", exp_q.size(), 32'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
